mul_fu_scheduler: RTL and testbench
===================================

// Module: mul_fu_scheduler
// PURPOSE
//  Shares one iterative multiplier (dadda_multiplier) between NUM_REQ multiply reservation-station ports.
//  Round-robin grant; translates RV32M funct3 to the multiplier's mul_type and selects the result half.
//  Tracks the branch tag and ROB index of the in-flight op, kills it on a matching flush and
//  broadcasts the 32-bit result on the CDB with a valid/ack handshake.
// PARAMETERS
//  NUM_REQ    4  number of requesting RS ports (>=2)
//  ROB_IDX_W  5  ROB index width
// PORTS
//  clk              in   1                    clock
//  rst              in   1                    synchronous active-high reset
//  req_valid        in   NUM_REQ              RS i holds a ready MUL-class op
//  req_ready        out  NUM_REQ              one-hot accept pulse; RS i drops its op next cycle
//  req_a, req_b     in   NUM_REQ x 32         operands per port
//  req_funct3       in   NUM_REQ x 3          000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
//  req_rob_idx      in   NUM_REQ x ROB_IDX_W  destination ROB entry
//  req_br_tag       in   NUM_REQ x branch_tag_t  speculation tag
//  flush            in   1                    branch-mispredict flush
//  flush_tag        in   branch_tag_t         tag being flushed
//  mul_start        out  1                    to multiplier start
//  mul_a, mul_b     out  32                   to multiplier a/b
//  mul_type         out  2                    00 UU, 01 SS, 10 SU (a signed)
//  mul_br_tag       out  branch_tag_t         to multiplier br_tag
//  mul_done         in   1                    multiplier done
//  mul_p            in   64                   multiplier product
//  mul_result_taken out  1                    to multiplier MUL_result_taken
//  cdb_valid        out  1                    result broadcast request
//  cdb_ack          in   1                    CDB accepted this cycle
//  cdb_data         out  32                   result
//  cdb_rob_idx      out  ROB_IDX_W            destination ROB entry
//  fu_busy          out  1                    high whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, every output 0 (req_ready, mul_start, mul_result_taken, cdb_valid, fu_busy).
//  States: IDLE -> ISSUE -> WAIT -> BCAST -> IDLE.
//  IDLE: if |req_valid and !flush, grant the first valid index at or after rr_ptr: req_ready[g]=1 (comb,
//    same cycle); latch a, b, funct3, rob_idx, br_tag; rr_ptr <= (g+1)%NUM_REQ; go to ISSUE.
//    No grant in any cycle with flush=1.
//  ISSUE (1 cycle): mul_start=1 unless flush; drives latched operands, mul_type, mul_br_tag.
//    Type map: MUL/MULHU->00, MULH->01, MULHSU->10. Go to WAIT.
//  WAIT: hold operands (mul_start=0); on mul_done go to BCAST.
//  BCAST: cdb_valid=1; cdb_data = funct3==000 ? mul_p[31:0] : mul_p[63:32].
//    On cdb_ack: mul_result_taken=1 that cycle, go to IDLE (no grant in that same cycle).
//  Kill: latched tag is killed when flush=1 and (sign equal ? (tag&ftag)==ftag : (tag&ftag)==tag).
//    In ISSUE/WAIT/BCAST a kill forces IDLE next cycle, cdb_valid=0 that cycle; the multiplier
//    self-cancels on the same flush. Kill in ISSUE suppresses mul_start.
//  Kill in BCAST coincident with cdb_ack: kill wins; no mul_result_taken.
//  Reset mid-operation: back to IDLE in one cycle, nothing broadcast.
//  Latency accept -> cdb_valid: 1 (ISSUE) + multiplier latency + 1.
// CONFIGURATION
//  MUL_SCHED_ZERO_BYPASS_EN defined: in IDLE a granted op with a==0 or b==0 skips ISSUE/WAIT,
//    goes straight to BCAST with cdb_data=0 and never pulses mul_start or mul_result_taken.
//  Not defined: every op goes through the multiplier.
// STRUCTURE
//  rv32i_types gains: mul_funct3_t enum, mul_type_t (2-bit), function br_tag_killed(tag, ftag).
//  Sub-module: rr_arbiter #(N) (req, ptr -> one-hot gnt, gnt_idx); reusable for other shared FUs.
// TESTING
//  1. Single req port0 MUL 7*6 -> one mul_start, cdb_data=42, rob_idx echoed, one mul_result_taken.
//  2. All 4 ports valid continuously -> grants 0,1,2,3,0 in order; each result broadcast once.
//  3. MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE;
//     MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  4. Flush with matching tag in WAIT -> IDLE next cycle, no cdb_valid; next grant proceeds normally.
//  5. cdb_ack held low 10 cycles in BCAST -> cdb_valid/data stable; no grant; done on ack.
//  6. With _EN: a=0, b=123 -> cdb_valid 1 cycle after accept, data 0, mul_start never asserted.

Source files
------------

// File: rtl/mul_fu_scheduler_pkg.sv
// Shared types for the multiply functional-unit scheduler: RV32M funct3 codes,
// multiplier operand-signedness selector, branch tags and the flush-kill rule.
package mul_fu_scheduler_pkg;

   localparam int BR_TAG_W = 4;

   typedef logic [BR_TAG_W-1:0] branch_tag_t;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011
   } mul_funct3_t;

   typedef enum logic [1:0] {
      MUL_UU = 2'b00,
      MUL_SS = 2'b01,
      MUL_SU = 2'b10
   } mul_type_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_BCAST = 2'b11
   } sched_state_t;

   // MUL only needs the low half, so it runs unsigned like MULHU.
   function automatic mul_type_t funct3_to_mul_type(input logic [2:0] f3);
      case (f3)
         F3_MULH:   return MUL_SS;
         F3_MULHSU: return MUL_SU;
         default:   return MUL_UU;
      endcase
   endfunction

   // The MSB is the tag's sign; the mask test direction flips when the signs differ.
   function automatic logic br_tag_killed(input branch_tag_t tag, input branch_tag_t ftag);
      if (tag[BR_TAG_W-1] == ftag[BR_TAG_W-1])
         return (tag & ftag) == ftag;
      return (tag & ftag) == tag;
   endfunction

endpackage

// File: rtl/mul_fu_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i (wrapping),
// returning both a one-hot grant and its index. Purely combinational.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             any_o
);

   logic [IDX_W-1:0] cand_idx [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_cand
         assign cand_idx[gi] = IDX_W'((int'(ptr_i) + gi) % N);
      end
   endgenerate

   // Scan from the farthest candidate back so the nearest one to ptr_i wins.
   always_comb begin
      gnt_idx_o = '0;
      any_o     = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[cand_idx[k]]) begin
            gnt_idx_o = cand_idx[k];
            any_o     = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_gnt
         assign gnt_o[gi] = any_o && (gnt_idx_o == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/mul_fu_scheduler.sv
// Shares one iterative multiplier between NUM_REQ reservation-station ports and
// broadcasts results on the CDB. Optional macro: MUL_SCHED_ZERO_BYPASS_EN.
module mul_fu_scheduler
   import mul_fu_scheduler_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ROB_IDX_W = 5
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0][31:0]            req_a,
   input  logic [NUM_REQ-1:0][31:0]            req_b,
   input  logic [NUM_REQ-1:0][2:0]             req_funct3,
   input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]   req_rob_idx,
   input  branch_tag_t [NUM_REQ-1:0]           req_br_tag,
   input  logic                                flush,
   input  branch_tag_t                         flush_tag,
   output logic                                mul_start,
   output logic [31:0]                         mul_a,
   output logic [31:0]                         mul_b,
   output logic [1:0]                          mul_type,
   output branch_tag_t                         mul_br_tag,
   input  logic                                mul_done,
   input  logic [63:0]                         mul_p,
   output logic                                mul_result_taken,
   output logic                                cdb_valid,
   input  logic                                cdb_ack,
   output logic [31:0]                         cdb_data,
   output logic [ROB_IDX_W-1:0]                cdb_rob_idx,
   output logic                                fu_busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_t           state_q;
   logic [IDX_W-1:0]       rr_ptr_q;
   logic [IDX_W-1:0]       rr_ptr_d;
   logic [31:0]            a_q;
   logic [31:0]            b_q;
   logic [2:0]             funct3_q;
   logic [ROB_IDX_W-1:0]   rob_q;
   branch_tag_t            tag_q;
   logic [31:0]            result_q;

   logic [NUM_REQ-1:0]     gnt;
   logic [IDX_W-1:0]       gnt_idx;
   logic                   gnt_any;
   logic                   grant_en;
   logic                   kill;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req_i     (req_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (gnt_any)
   );

   assign grant_en  = (state_q == S_IDLE) && !flush && !rst;
   assign req_ready = grant_en ? gnt : '0;
   assign rr_ptr_d  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   assign kill      = flush && (state_q != S_IDLE) && br_tag_killed(tag_q, flush_tag);

   assign mul_start   = (state_q == S_ISSUE) && !kill;
   assign mul_a       = a_q;
   assign mul_b       = b_q;
   assign mul_type    = funct3_to_mul_type(funct3_q);
   assign mul_br_tag  = tag_q;
   assign cdb_valid   = (state_q == S_BCAST) && !kill;
   assign cdb_data    = result_q;
   assign cdb_rob_idx = rob_q;
   assign fu_busy     = (state_q != S_IDLE);

`ifdef MUL_SCHED_ZERO_BYPASS_EN
   logic bypass_q;
   // A bypassed op never touched the multiplier, so there is nothing to release.
   assign mul_result_taken = cdb_valid && cdb_ack && !bypass_q;
`else
   assign mul_result_taken = cdb_valid && cdb_ack;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         funct3_q <= '0;
         rob_q    <= '0;
         tag_q    <= '0;
         result_q <= '0;
`ifdef MUL_SCHED_ZERO_BYPASS_EN
         bypass_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_en && gnt_any) begin
                  a_q      <= req_a[gnt_idx];
                  b_q      <= req_b[gnt_idx];
                  funct3_q <= req_funct3[gnt_idx];
                  rob_q    <= req_rob_idx[gnt_idx];
                  tag_q    <= req_br_tag[gnt_idx];
                  rr_ptr_q <= rr_ptr_d;
`ifdef MUL_SCHED_ZERO_BYPASS_EN
                  if (req_a[gnt_idx] == '0 || req_b[gnt_idx] == '0) begin
                     state_q  <= S_BCAST;
                     result_q <= '0;
                     bypass_q <= 1'b1;
                  end else begin
                     state_q  <= S_ISSUE;
                     bypass_q <= 1'b0;
                  end
`else
                  state_q <= S_ISSUE;
`endif
               end
            end
            S_ISSUE: state_q <= kill ? S_IDLE : S_WAIT;
            S_WAIT: begin
               if (kill) begin
                  state_q <= S_IDLE;
               end else if (mul_done) begin
                  result_q <= (funct3_q == F3_MUL) ? mul_p[31:0] : mul_p[63:32];
                  state_q  <= S_BCAST;
               end
            end
            S_BCAST: begin
               if (kill || cdb_ack)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_fu_scheduler.sv
// Self-checking bench for mul_fu_scheduler: behavioural multiplier stub, RS-side
// driver and an arithmetic reference model of RV32M results.
module tb_mul_fu_scheduler;
   import mul_fu_scheduler_pkg::*;

   localparam int NUM_REQ   = 4;
   localparam int ROB_IDX_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NUM_REQ-1:0]                req_valid = '0;
   logic [NUM_REQ-1:0]                req_ready;
   logic [NUM_REQ-1:0][31:0]          req_a = '0;
   logic [NUM_REQ-1:0][31:0]          req_b = '0;
   logic [NUM_REQ-1:0][2:0]           req_funct3 = '0;
   logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx = '0;
   branch_tag_t [NUM_REQ-1:0]         req_br_tag = '0;
   logic                              flush = 1'b0;
   branch_tag_t                       flush_tag = '0;
   logic                              mul_start;
   logic [31:0]                       mul_a, mul_b;
   logic [1:0]                        mul_type;
   branch_tag_t                       mul_br_tag;
   logic                              mul_done;
   logic [63:0]                       mul_p;
   logic                              mul_result_taken;
   logic                              cdb_valid;
   logic                              cdb_ack = 1'b1;
   logic [31:0]                       cdb_data;
   logic [ROB_IDX_W-1:0]              cdb_rob_idx;
   logic                              fu_busy;

   mul_fu_scheduler #(.NUM_REQ(NUM_REQ), .ROB_IDX_W(ROB_IDX_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_funct3(req_funct3),
      .req_rob_idx(req_rob_idx), .req_br_tag(req_br_tag),
      .flush(flush), .flush_tag(flush_tag),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_type(mul_type),
      .mul_br_tag(mul_br_tag), .mul_done(mul_done), .mul_p(mul_p),
      .mul_result_taken(mul_result_taken),
      .cdb_valid(cdb_valid), .cdb_ack(cdb_ack), .cdb_data(cdb_data),
      .cdb_rob_idx(cdb_rob_idx), .fu_busy(fu_busy)
   );

   int checks = 0;
   int errors = 0;

   int            grant_q[$];
   logic [36:0]   exp_q[$];
   logic [36:0]   got_q[$];
   int            n_start, n_taken, n_multi;
   int            pending_port = -1;
   bit            auto_reload = 1'b0;
   int            lat_min = 6, lat_max = 6;

   // Reference RV32M results from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         default: begin p = ua * ub; return p[63:32]; end
      endcase
   endfunction

   function automatic bit tb_killed(input logic [3:0] t, input logic [3:0] f);
      if (t[3] == f[3]) return (t & f) == f;
      return (t & f) == t;
   endfunction

   // Multiplier stub: variable latency, holds done/product until taken or cancelled.
   logic        m_busy;
   int          m_cnt;
   logic [63:0] m_p;
   logic [3:0]  m_tag;
   assign mul_p = m_p;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0; mul_done <= 1'b0; m_cnt <= 0; m_p <= '0; m_tag <= '0;
      end else if (m_busy && flush && tb_killed(m_tag, flush_tag)) begin
         m_busy <= 1'b0; mul_done <= 1'b0;
      end else if (mul_start) begin
         m_busy   <= 1'b1;
         mul_done <= 1'b0;
         m_cnt    <= int'($urandom_range(lat_min, lat_max));
         m_tag    <= mul_br_tag;
         case (mul_type)
            2'b01:   m_p <= 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}));
            2'b10:   m_p <= 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({32'b0, mul_b}));
            default: m_p <= {32'b0, mul_a} * {32'b0, mul_b};
         endcase
      end else if (m_busy) begin
         if (mul_result_taken) begin
            m_busy <= 1'b0; mul_done <= 1'b0;
         end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
         end else begin
            mul_done <= 1'b1;
         end
      end
   end

   // Event log sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mul_start) n_start++;
            if (mul_result_taken) n_taken++;
            if ($countones(req_ready) > 1) n_multi++;
            for (int p = 0; p < NUM_REQ; p++) begin
               if (req_ready[p]) begin
                  grant_q.push_back(p);
                  exp_q.push_back({req_rob_idx[p], ref_result(req_funct3[p], req_a[p], req_b[p])});
                  pending_port = p;
               end
            end
            if (cdb_valid && cdb_ack) got_q.push_back({cdb_rob_idx, cdb_data});
         end
      end
   end

   task automatic load_random(input int p);
      req_a[p]       = $urandom;
      req_b[p]       = $urandom;
      req_funct3[p]  = 3'($urandom_range(0, 3));
      req_rob_idx[p] = ROB_IDX_W'($urandom);
      req_br_tag[p]  = '0;
      req_valid[p]   = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (pending_port >= 0) begin
         if (auto_reload) load_random(pending_port);
         else req_valid[pending_port] = 1'b0;
         pending_port = -1;
      end
   endtask

   task automatic clear_log();
      grant_q.delete(); exp_q.delete(); got_q.delete();
      n_start = 0; n_taken = 0; n_multi = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; flush = 1'b0; cdb_ack = 1'b1; auto_reload = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      pending_port = -1;
      clear_log();
   endtask

   task automatic submit(input int p, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [ROB_IDX_W-1:0] rob, input logic [3:0] tag);
      req_a[p] = a; req_b[p] = b; req_funct3[p] = f3;
      req_rob_idx[p] = rob; req_br_tag[p] = tag; req_valid[p] = 1'b1;
   endtask

   task automatic wait_results(input int n, input int budget, output int got);
      int cyc = 0;
      while (got_q.size() < n && cyc < budget) begin
         tick();
         cyc++;
      end
      got = got_q.size();
   endtask

   task automatic wait_grant(input int budget, output int port);
      port = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         for (int p = 0; p < NUM_REQ; p++) if (req_ready[p]) port = p;
         if (port >= 0) return;
         tick();
      end
   endtask

   task automatic wait_cdb(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (cdb_valid) begin ok = 1'b1; return; end
         tick();
      end
   endtask

   task automatic run_op(input int p, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output int got);
      clear_log();
      submit(p, f3, a, b, ROB_IDX_W'(p + 1), 4'b0);
      wait_results(1, 200, got);
      data = (got_q.size() > 0) ? got_q[0][31:0] : 32'hDEAD_BEEF;
   endtask

   task automatic test_reset();
      int got;
      rst = 1'b1;
      for (int p = 0; p < NUM_REQ; p++) load_random(p);
      repeat (2) tick();
      @(negedge clk);
      checks++;
      if (req_ready !== '0 || mul_start !== 1'b0 || mul_result_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs req_ready=%b mul_start=%b taken=%b required 0", req_ready, mul_start, mul_result_taken);
      end
      checks++;
      if (cdb_valid !== 1'b0 || fu_busy !== 1'b0 || cdb_data !== '0) begin
         errors++;
         $display("FAIL reset_cdb cdb_valid=%b fu_busy=%b cdb_data=%h required 0", cdb_valid, fu_busy, cdb_data);
      end
      tick();
      rst = 1'b0;
      clear_log();
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL reset_first_grant req_ready=%b required 0001", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (fu_busy !== 1'b0 || cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_midop fu_busy=%b cdb_valid=%b required 0 0", fu_busy, cdb_valid);
      end
      wait_results(1, 12, got);
      checks++;
      if (got !== 0) begin
         errors++;
         $display("FAIL reset_midop_bcast results=%0d required 0", got);
      end
      lat_min = 1; lat_max = 5;
   endtask

   task automatic test_single();
      int got;
      do_reset();
      submit(0, 3'b000, 32'd7, 32'd6, 5'd9, 4'b0);
      wait_results(1, 200, got);
      checks++;
      if (got !== 1) begin errors++; $display("FAIL single_count results=%0d required 1", got); end
      if (got_q.size() > 0) begin
         checks++;
         if (got_q[0] !== {5'd9, 32'd42}) begin
            errors++;
            $display("FAIL single_result rob/data=%h required %h", got_q[0], {5'd9, 32'd42});
         end
      end
      checks++;
      if (n_start !== 1 || n_taken !== 1) begin
         errors++;
         $display("FAIL single_handshake starts=%0d taken=%0d required 1 1", n_start, n_taken);
      end
   endtask

   task automatic test_round_robin();
      int got, cyc;
      do_reset();
      auto_reload = 1'b1;
      for (int p = 0; p < NUM_REQ; p++) load_random(p);
      cyc = 0;
      while (grant_q.size() < 5 && cyc < 400) begin tick(); cyc++; end
      req_valid = '0;
      auto_reload = 1'b0;
      wait_results(5, 200, got);
      checks++;
      if (got !== 5 || grant_q.size() !== 5) begin
         errors++;
         $display("FAIL rr_count results=%0d grants=%0d required 5 5", got, grant_q.size());
      end
      for (int i = 0; i < 5 && i < grant_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (grant_q[i] !== i % NUM_REQ) begin
            errors++;
            $display("FAIL rr_order[%0d] port=%0d required %0d", i, grant_q[i], i % NUM_REQ);
         end
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rr_result[%0d] rob/data=%h required %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (n_multi !== 0) begin errors++; $display("FAIL rr_onehot multi_grants=%0d required 0", n_multi); end
   endtask

   task automatic test_mulh();
      logic [31:0] d;
      int got;
      run_op(2, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, got);
      checks++;
      if (got !== 1 || d !== 32'h0000_0000) begin errors++; $display("FAIL mulh data=%h required 00000000", d); end
      run_op(2, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, got);
      checks++;
      if (got !== 1 || d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu data=%h required fffffffe", d); end
      run_op(1, 3'b010, 32'hFFFF_FFFF, 32'd2, d, got);
      checks++;
      if (got !== 1 || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu data=%h required ffffffff", d); end
   endtask

   task automatic test_random();
      int got, p;
      logic [31:0] a, b;
      for (int i = 0; i < 16; i++) begin
         clear_log();
         p = int'($urandom_range(0, NUM_REQ - 1));
         a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
         b = (i % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
         submit(p, 3'($urandom_range(0, 3)), a, b, ROB_IDX_W'($urandom), 4'b0);
         wait_results(1, 200, got);
         checks++;
         if (got !== 1 || exp_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL random[%0d] f3=%0d a=%h b=%h rob/data=%h required %h", i, req_funct3[p], a, b,
                     (got_q.size() > 0) ? got_q[0] : 37'h0, (exp_q.size() > 0) ? exp_q[0] : 37'h0);
         end
      end
   endtask

   task automatic test_flush();
      int got, port;
      bit ok;
      do_reset();
      lat_min = 8; lat_max = 8;
      submit(1, 3'b000, 32'd5, 32'd9, 5'd3, 4'b0011);
      wait_grant(50, port);
      checks++;
      if (port !== 1) begin errors++; $display("FAIL flush_grant port=%0d required 1", port); end
      tick();
      @(negedge clk);
      checks++;
      if (mul_start !== 1'b1) begin errors++; $display("FAIL flush_issue mul_start=%b required 1", mul_start); end
      tick();
      tick();
      flush = 1'b1; flush_tag = 4'b0011;
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_cdb cdb_valid=%b required 0", cdb_valid); end
      tick();
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if (fu_busy !== 1'b0) begin errors++; $display("FAIL flush_wait_idle fu_busy=%b required 0", fu_busy); end
      wait_results(1, 20, got);
      checks++;
      if (got !== 0 || n_taken !== 0) begin
         errors++;
         $display("FAIL flush_wait_nobcast results=%0d taken=%0d required 0 0", got, n_taken);
      end
      lat_min = 1; lat_max = 5;

      // Flush with a non-matching tag must leave the op alone.
      clear_log();
      submit(3, 3'b001, 32'hFFFF_0000, 32'h0001_0000, 5'd11, 4'b0011);
      wait_grant(50, port);
      tick();
      tick();
      flush = 1'b1; flush_tag = 4'b0100;
      tick();
      flush = 1'b0;
      wait_results(1, 200, got);
      checks++;
      if (got !== 1 || got_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL flush_nomatch results=%0d rob/data=%h required %h", got,
                  (got_q.size() > 0) ? got_q[0] : 37'h0, (exp_q.size() > 0) ? exp_q[0] : 37'h0);
      end

      // No grant while flush is high.
      clear_log();
      flush = 1'b1; flush_tag = 4'b0111;
      submit(0, 3'b011, 32'h10, 32'h20, 5'd2, 4'b0);
      @(negedge clk);
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL flush_idle_nogrant req_ready=%b required 0000", req_ready); end
      tick();
      flush = 1'b0;
      wait_results(1, 200, got);
      checks++;
      if (got !== 1 || got_q[0] !== {5'd2, 32'd0}) begin
         errors++;
         $display("FAIL flush_idle_after results=%0d rob/data=%h required %h", got,
                  (got_q.size() > 0) ? got_q[0] : 37'h0, {5'd2, 32'd0});
      end

      // Kill in BCAST coincident with ack; signs differ, (tag&ftag)==tag kills.
      clear_log();
      cdb_ack = 1'b0;
      submit(2, 3'b000, 32'd100, 32'd200, 5'd6, 4'b0010);
      wait_cdb(200, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL bkill_reach_bcast cdb_valid never seen"); end
      tick();
      flush = 1'b1; flush_tag = 4'b1010; cdb_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b0 || mul_result_taken !== 1'b0) begin
         errors++;
         $display("FAIL bkill_outputs cdb_valid=%b taken=%b required 0 0", cdb_valid, mul_result_taken);
      end
      tick();
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if (fu_busy !== 1'b0) begin errors++; $display("FAIL bkill_idle fu_busy=%b required 0", fu_busy); end
      wait_results(1, 8, got);
      checks++;
      if (got !== 0 || n_taken !== 0) begin
         errors++;
         $display("FAIL bkill_nobcast results=%0d taken=%0d required 0 0", got, n_taken);
      end
   endtask

   task automatic test_stall();
      int got;
      bit ok;
      logic [36:0] e;
      do_reset();
      cdb_ack = 1'b0;
      submit(0, 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 4'b0);
      wait_cdb(200, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL stall_reach_bcast cdb_valid never seen"); end
      e = (exp_q.size() > 0) ? exp_q[0] : 37'h0;
      submit(1, 3'b000, 32'd1000, 32'd3, 5'd8, 4'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clk);
         checks++;
         if (cdb_valid !== 1'b1 || {cdb_rob_idx, cdb_data} !== e || req_ready !== '0) begin
            errors++;
            $display("FAIL stall_hold[%0d] valid=%b rob/data=%h req_ready=%b required 1 %h 0000", i, cdb_valid,
                     {cdb_rob_idx, cdb_data}, req_ready, e);
         end
      end
      tick();
      cdb_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (mul_result_taken !== 1'b1 || req_ready !== '0) begin
         errors++;
         $display("FAIL stall_ack taken=%b req_ready=%b required 1 0000", mul_result_taken, req_ready);
      end
      wait_results(2, 200, got);
      checks++;
      if (got !== 2 || got_q[0] !== e || got_q[1] !== {5'd8, 32'd3000}) begin
         errors++;
         $display("FAIL stall_results count=%0d second=%h required 2 %h", got,
                  (got_q.size() > 1) ? got_q[1] : 37'h0, {5'd8, 32'd3000});
      end
   endtask

`ifdef MUL_SCHED_ZERO_BYPASS_EN
   task automatic test_zero_bypass();
      int got, port;
      do_reset();
      submit(0, 3'b000, 32'd0, 32'd123, 5'd4, 4'b0);
      wait_grant(50, port);
      tick();
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b1 || cdb_data !== 32'd0) begin
         errors++;
         $display("FAIL bypass_latency cdb_valid=%b data=%h required 1 00000000", cdb_valid, cdb_data);
      end
      wait_results(1, 10, got);
      repeat (3) tick();
      checks++;
      if (got !== 1 || n_start !== 0 || n_taken !== 0) begin
         errors++;
         $display("FAIL bypass_handshake results=%0d starts=%0d taken=%0d required 1 0 0", got, n_start, n_taken);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_mulh();
      test_random();
      test_flush();
      test_stall();
`ifdef MUL_SCHED_ZERO_BYPASS_EN
      test_zero_bypass();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
